// File: rtl/ppa_slice_sequencer.sv
// Slice-serial WIDTH-bit adder sequencer around an external 4-bit combinational adder.
// Optional PPA_SEQ_SUB_EN adds an in_sub_i port that turns the operation into A - B.
module ppa_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_cin_i,
`ifdef PPA_SEQ_SUB_EN
    input  logic             in_sub_i,
`endif
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_cin_o,
    input  logic [3:0]       add_sum_i,
    input  logic             add_cout_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_cout_o
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH+3:0] sum_shift;

    // in_ready is forced low while reset is held, even though the state is already IDLE
    assign in_ready_o = ~rst_i & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
    assign accept     = in_valid_i & in_ready_o;
    assign sum_shift  = {add_sum_i, sum_q};

`ifdef PPA_SEQ_SUB_EN
    assign b_load = in_sub_i ? ~in_b_i : in_b_i;
    assign c_load = in_sub_i ? 1'b1 : in_cin_i;
`else
    assign b_load = in_b_i;
    assign c_load = in_cin_i;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        add_a_o     = 4'h0;
        add_b_o     = 4'h0;
        add_cin_o   = 1'b0;
        out_valid_o = 1'b0;
        out_sum_o   = '0;
        out_cout_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a_i;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a_o   = a_q[3:0];
                add_b_o   = b_q[3:0];
                add_cin_o = carry_q;
                a_d       = a_q >> 4;
                b_d       = b_q >> 4;
                sum_d     = sum_shift[WIDTH+3:4];
                carry_d   = add_cout_i;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                out_sum_o   = sum_q;
                out_cout_o  = carry_q;
                if (out_ready_i) begin
                    if (accept) begin
                        a_d     = in_a_i;
                        b_d     = b_load;
                        carry_d = c_load;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ppa_slice_sequencer.sv
// Scoreboard bench for ppa_slice_sequencer (WIDTH=16) with a behavioural 4-bit adder.
module tb_ppa_slice_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
`ifdef PPA_SEQ_SUB_EN
    logic        in_sub = 1'b0;
`endif
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    ppa_slice_sequencer #(.WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_cin_i    (in_cin),
`ifdef PPA_SEQ_SUB_EN
        .in_sub_i    (in_sub),
`endif
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_sum_i   (add_sum),
        .add_cout_i  (add_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_cout_o  (out_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every consumed result is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {15'd0, out_cout, out_sum}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("result_sum", 32'(out_sum), 32'(e[15:0]));
                chk("result_cout", 32'(out_cout), 32'(e[16]));
            end
        end
    end

    // Drives a request from posedge+1 and returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic push, input logic [15:0] es,
                        input logic ec);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
`ifdef PPA_SEQ_SUB_EN
        in_sub = sub;
`else
        if (sub) $display("note: subtract request issued without PPA_SEQ_SUB_EN");
`endif
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) exp_q.push_back({ec, es});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] cin_seq;
        cin_seq = 4'b1110;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_out_sum", 32'(out_sum), 32'd0);
        chk("rel_add_a", 32'(add_a), 32'd0);

        // 0x1234 + 0x4321, latency and in_valid-ignored-in-RUN
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat_out_valid_low", 32'(out_valid), 32'd0);
            chk("run_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid_low", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_out_valid_4", 32'(out_valid), 32'd1);
        drain();

        // full ripple carry
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ripple_add_cin", 32'(add_cin), 32'(cin_seq[k]));
        end
        drain();

        // output stall with a pending request accepted on the releasing edge
        out_ready = 1'b0;
        send(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b1, 16'h100F, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = 16'h0ABC; in_b = 16'h1111; in_cin = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_sum", 32'(out_sum), 32'h100F);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("done_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back({1'b0, 16'h1BCD});
        @(negedge clk);
        chk("chain_out_valid", 32'(out_valid), 32'd0);
        chk("chain_add_a", 32'(add_a), 32'hC);
        drain();

        // reset during the second RUN cycle aborts the request
        send(16'h3333, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_out_sum", 32'(out_sum), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        chk("abort_add_cin", 32'(add_cin), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        drain();

`ifdef PPA_SEQ_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        drain();
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1);
        drain();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
